// File: rtl/tpu_seq.sv
// Sequencer for the TPU matrix unit: registers operand writes into the array,
// times the systolic fill/compute/drain window and stalls the front end while busy.
module tpu_seq #(
    parameter int DIM    = 8,
    parameter int DATA_W = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 start_i,
    input  logic                                 wren_a_i,
    input  logic                                 wren_b_i,
    input  logic                                 wren_c_i,
    input  logic [4:0]                           row_i,
    input  logic [4:0]                           col_i,
    input  logic [DATA_W-1:0]                    data_i,
    output logic                                 a_wr_o,
    output logic                                 b_wr_o,
    output logic                                 c_wr_o,
    output logic [4:0]                           wr_row_o,
    output logic [4:0]                           wr_col_o,
    output logic [DATA_W-1:0]                    wr_data_o,
    output logic                                 step_o,
    output logic [$clog2(3*DIM-2+1)-1:0]         step_cnt_o,
    output logic                                 done_o,
    output logic                                 busy_o,
    output logic                                 stall_o,
    output logic                                 err_o
);

    localparam int RUN_CYC = 3*DIM-2;
    localparam int CNT_W   = $clog2(RUN_CYC+1);
    localparam logic [5:0]       DIM_L    = 6'(DIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYC-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               a_wr_q, a_wr_d;
    logic               b_wr_q, b_wr_d;
    logic               c_wr_q, c_wr_d;
    logic [4:0]         row_q, row_d;
    logic [4:0]         col_q, col_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               any_req;
    logic               req_vld;
    logic [2:0]         n_req;
    logic               multi_req;
    logic               addr_ok;

    assign any_req   = start_i | wren_a_i | wren_b_i | wren_c_i;
    assign req_vld   = any_req & ~flush_i;
    assign n_req     = {2'b00, start_i} + {2'b00, wren_a_i} + {2'b00, wren_b_i} + {2'b00, wren_c_i};
    assign multi_req = (n_req > 3'd1);
    assign addr_ok   = ({1'b0, row_i} < DIM_L) && ({1'b0, col_i} < DIM_L);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        a_wr_d  = 1'b0;
        b_wr_d  = 1'b0;
        c_wr_d  = 1'b0;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (start_i) begin
                        // start wins and clears err, but a dropped companion write re-flags it
                        state_d = RUN;
                        cnt_d   = '0;
                        err_d   = multi_req;
                    end else if (addr_ok) begin
                        c_wr_d = wren_c_i;
                        b_wr_d = wren_b_i & ~wren_c_i;
                        a_wr_d = wren_a_i & ~wren_b_i & ~wren_c_i;
                        row_d  = row_i;
                        col_d  = col_i;
                        data_d = data_i;
                        err_d  = err_q | multi_req;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            a_wr_q  <= 1'b0;
            b_wr_q  <= 1'b0;
            c_wr_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            a_wr_q  <= a_wr_d;
            b_wr_q  <= b_wr_d;
            c_wr_q  <= c_wr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

    assign a_wr_o     = a_wr_q;
    assign b_wr_o     = b_wr_q;
    assign c_wr_o     = c_wr_q;
    assign wr_row_o   = row_q;
    assign wr_col_o   = col_q;
    assign wr_data_o  = data_q;
    assign step_o     = (state_q == RUN);
    assign step_cnt_o = cnt_q;
    assign done_o     = (state_q == DONE);
    assign busy_o     = (state_q != IDLE);
    assign stall_o    = busy_o & any_req & ~flush_i;
    assign err_o      = err_q;

endmodule

// File: tb/tb_tpu_seq.sv
// Directed self-checking bench for tpu_seq at DIM=8 (22-cycle compute window).
module tb_tpu_seq;

    localparam int DIM    = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(3*DIM-2+1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              start = 1'b0;
    logic              wren_a = 1'b0;
    logic              wren_b = 1'b0;
    logic              wren_c = 1'b0;
    logic [4:0]        row = '0;
    logic [4:0]        col = '0;
    logic [DATA_W-1:0] data = '0;
    logic              a_wr, b_wr, c_wr;
    logic [4:0]        wr_row, wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              step;
    logic [CNT_W-1:0]  step_cnt;
    logic              done, busy, stall, err;

    int checks = 0;
    int errors = 0;

    tpu_seq #(.DIM(DIM), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start),
        .wren_a_i(wren_a), .wren_b_i(wren_b), .wren_c_i(wren_c),
        .row_i(row), .col_i(col), .data_i(data),
        .a_wr_o(a_wr), .b_wr_o(b_wr), .c_wr_o(c_wr),
        .wr_row_o(wr_row), .wr_col_o(wr_col), .wr_data_o(wr_data),
        .step_o(step), .step_cnt_o(step_cnt), .done_o(done),
        .busy_o(busy), .stall_o(stall), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int steps;
        int dones;
        int cyc;

        // reset state
        tick();
        check("rst_busy", busy, 0);
        check("rst_step", step, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        check("rst_cnt", step_cnt, 0);
        check("rst_wr", {a_wr, b_wr, c_wr}, 0);
        check("rst_wdata", {wr_row, wr_col, wr_data}, 0);
        rst = 1'b0;
        tick();

        // in-range A write
        wren_a = 1'b1; row = 5'd2; col = 5'd3; data = 32'hDEADBEEF;
        tick();
        wren_a = 1'b0; row = '0; col = '0; data = '0;
        #1;
        check("wa_strobe", {a_wr, b_wr, c_wr}, 3'b100);
        check("wa_row", wr_row, 2);
        check("wa_col", wr_col, 3);
        check("wa_data", wr_data, 32'hDEADBEEF);
        check("wa_err", err, 0);
        tick();
        check("wa_pulse_end", a_wr, 0);
        check("wa_data_hold", wr_data, 32'hDEADBEEF);

        // start at T, B write held from T+5 while busy
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 5) begin
                wren_b = 1'b1; row = 5'd1; col = 5'd4; data = 32'h0000_1234;
            end
            #1;
            check("run_step", step, 1);
            check("run_cnt", step_cnt, k - 1);
            check("run_busy", busy, 1);
            check("run_stall", stall, (k >= 5));
            check("run_bwr", b_wr, 0);
            if (done) dones++;
            if (k < 22) tick();
        end
        check("run_no_done", dones, 0);
        tick();
        check("done_pulse", done, 1);
        check("done_step", step, 0);
        check("done_cnt", step_cnt, 0);
        check("done_stall", stall, 1);
        check("done_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_stall", stall, 0);
        check("idle_bwr", b_wr, 0);
        tick();
        wren_b = 1'b0; row = '0; col = '0; data = '0;
        #1;
        check("held_b_strobe", {a_wr, b_wr, c_wr}, 3'b010);
        check("held_b_row", wr_row, 1);
        check("held_b_col", wr_col, 4);
        check("held_b_data", wr_data, 32'h0000_1234);
        tick();
        check("held_b_end", b_wr, 0);

        // out-of-range C write
        wren_c = 1'b1; row = 5'd8; col = 5'd0; data = 32'hCAFE_0000;
        tick();
        wren_c = 1'b0; row = '0; data = '0;
        #1;
        check("oor_no_strobe", c_wr, 0);
        check("oor_err", err, 1);
        check("oor_data_kept", wr_data, 32'h0000_1234);
        tick();
        check("oor_err_sticky", err, 1);

        // accepted start clears err
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("start_clr_err", err, 0);
        check("start2_busy", busy, 1);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check("run2_len", cyc, 23);

        // flushed start
        start = 1'b1; flush = 1'b1;
        #1;
        check("flush_stall", stall, 0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_busy", busy, 0);
        check("flush_step", step, 0);

        // start with simultaneous A write
        start = 1'b1; wren_a = 1'b1; row = 5'd0; col = 5'd0; data = 32'h5;
        tick();
        start = 1'b0; wren_a = 1'b0; data = '0;
        #1;
        check("sim_busy", busy, 1);
        check("sim_no_awr", a_wr, 0);
        check("sim_err", err, 1);
        check("sim_data_kept", wr_data, 32'h0000_1234);

        // asynchronous reset at RUN cycle 10
        for (int k = 0; k < 10; k++) tick();
        wren_a = 1'b1;
        #1;
        check("mid_cnt", step_cnt, 10);
        check("mid_stall", stall, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_step", step, 0);
        check("arst_stall", stall, 0);
        check("arst_err", err, 0);
        check("arst_done", done, 0);
        check("arst_data", wr_data, 0);
        wren_a = 1'b0;
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done) dones++;
        end
        check("arst_no_done", dones, 0);

        // full window after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        steps = 0;
        dones = 0;
        cyc = 0;
        while (busy && cyc < 40) begin
            if (step) steps++;
            if (done) dones++;
            tick();
            cyc++;
        end
        check("post_rst_steps", steps, 22);
        check("post_rst_dones", dones, 1);
        check("post_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_seq.md
# tpu_seq

Sequencer for the matrix (TPU) unit fed by the ID/EX stage. It accepts the decoded TPU controls (start, A/B/C operand writes, row/col coordinates, data) and registers operand writes into the array. A start runs the systolic computation for a fixed fill/compute/drain window. While the array is busy, it holds the front end with a stall so later TPU instructions wait in ID/EX.

## Interface
- DIM, 8: array dimension (rows = cols = DIM); legal 2..16
- DATA_W, 32: operand/data width
- RUN_CYC, 3*DIM-2: compute window length in cycles (derived, not overridden)
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  cancels the request presented this cycle
- start_i  in  1  TPU start from ID/EX
- wren_a_i / wren_b_i / wren_c_i  in  1 each  operand-matrix write requests from ID/EX
- row_i  in  5  target row
- col_i  in  5  target column
- data_i  in  DATA_W  write data (rs1 value)
- a_wr_o / b_wr_o / c_wr_o  out  1 each  registered write strobes to the array
- wr_row_o  out  5  registered row
- wr_col_o  out  5  registered column
- wr_data_o  out  DATA_W  registered data
- step_o  out  1  systolic shift enable, high every RUN cycle
- step_cnt_o  out  $clog2(RUN_CYC+1)  current RUN cycle index, 0-based
- done_o  out  1  one-cycle completion pulse
- busy_o  out  1  state != IDLE
- stall_o  out  1  combinational: busy_o & any request & ~flush_i
- err_o  out  1  sticky error flag

## Operation
- Request valid when (start_i | wren_*_i) & ~flush_i.
- States:
  - IDLE: accepts requests.
  - RUN: counter 0..RUN_CYC-1, step_o=1.
  - DONE: done_o=1, one cycle.
  - Transitions: IDLE→RUN on valid start_i; RUN→DONE when count==RUN_CYC-1; DONE→IDLE unconditionally.
- IDLE priority within one cycle: start > C > B > A. Only the highest-priority request is honored. If more than one request is set, the lower ones are dropped and err_o is set.
- Write accepted in IDLE with row_i<DIM and col_i<DIM:
  - next cycle the matching *_wr_o pulses for one cycle;
  - wr_row_o/wr_col_o/wr_data_o carry the captured values and hold until the next accepted write.
- Write with row_i>=DIM or col_i>=DIM: dropped, no strobe, err_o set.
- Requests presented while busy (RUN or DONE): not accepted; stall_o=1. ID/EX holds them, and they are accepted in the first IDLE cycle.
- flush_i: request ignored in that cycle. flush_i does not abort a RUN in progress.
- err_o: sticky. Cleared by reset or by the next accepted start (start takes effect even when it also sets err via a simultaneous write).
- start accepted in IDLE during the same cycle as a write strobe from the previous cycle: legal; the strobe completes.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - a_wr_o/b_wr_o/c_wr_o/step_o/done_o/busy_o/err_o = 0;
  - wr_row_o/wr_col_o = 0, wr_data_o = 0;
  - stall_o = 0 (busy is 0).
- Write latency: request at edge T → strobe high during cycle T+1.
- Start accepted in cycle T:
  - RUN in cycles T+1..T+RUN_CYC, with step_cnt_o = 0..RUN_CYC-1;
  - DONE in cycle T+RUN_CYC+1;
  - IDLE in cycle T+RUN_CYC+2.
- DIM=8: RUN lasts 22 cycles, done_o at T+23, next acceptance at T+24.
- busy_o and stall_o are high from T+1 through the DONE cycle inclusive.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronous). No done_o is generated. A pending stall releases.
- step_cnt_o = 0 outside RUN.

## Test plan
- Reset, then wren_a_i=1, row_i=2, col_i=3, data_i=0xDEADBEEF in IDLE → a_wr_o=1 next cycle only, wr_row_o=2, wr_col_o=3, wr_data_o=0xDEADBEEF, err_o=0.
- start_i pulse at cycle T (DIM=8):
  - step_o high for exactly 22 cycles, step_cnt_o 0..21;
  - done_o single pulse at T+23;
  - busy_o low at T+24.
- wren_b_i held from T+5 through the end of the run → stall_o=1 T+5..T+23, b_wr_o pulses at T+25, stall_o=0 at T+24.
- wren_c_i with row_i=8 (DIM=8) → no c_wr_o, err_o=1 and stays 1; the next accepted start_i clears err_o.
- start_i with flush_i=1 → stays IDLE, stall_o=0, no step_o. Simultaneous start_i+wren_a_i → RUN entered, no a_wr_o, err_o=1.
- rst_i asserted at RUN cycle 10 → busy_o/step_o/stall_o drop in the same cycle, no done_o. After release, a start runs a full 22-cycle window.
